// File: rtl/sc_sched_pkg.sv
// Shared types and constants for the stochastic-computing FIR frame scheduler.
package sc_sched_pkg;

    localparam int PH_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_IN = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    // Stage-1 tap-bank select per phase, phase 0 in the low bits: 0->3, 1->2, 2->0, 3->1.
    localparam logic [4*PH_W-1:0] MUX_LUT = {2'd1, 2'd0, 2'd2, 2'd3};

    function automatic logic [PH_W-1:0] mux_lookup(input logic [PH_W-1:0] ph);
        return MUX_LUT[{ph, 1'b0} +: PH_W];
    endfunction

    function automatic int frame_len(input int n);
        return 1 << n;
    endfunction

    function automatic int phase_len(input int n);
        return 1 << (n - 2);
    endfunction

endpackage

// File: rtl/sc_frame_scheduler.sv
// Frame scheduler for the shared SC FIR bank: owns the bitstream counter, the sample
// handshake, and the single-clock phase/select/strobe enables consumed by the datapath.
module sc_frame_scheduler
    import sc_sched_pkg::*;
#(
    parameter int N      = 12,
    parameter int NFRM_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [NFRM_W-1:0] num_frames,
    input  logic              stop,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              sample_en,
    output logic [N-3:0]      sc_sel,
    output logic [PH_W-1:0]   phase,
    output logic [3:0]        phase_start,
    output logic [3:0]        phase_done,
    output logic [PH_W-1:0]   mux_sel,
    output logic              frame_done,
    output logic              busy,
    output logic              done
);

    state_t            state_reg, state_next;
    logic [N-1:0]      cnt_reg;
    logic [NFRM_W-1:0] frames_left_reg;
    logic              forever_reg;
    logic              stop_pend_reg;
    logic              done_reg;

    logic              run, wait_in, frame_end, exit_run, take_sample;
    logic [N-3:0]      sel_bits;
    logic [PH_W-1:0]   ph_bits;

    always_comb begin
        run         = (state_reg == ST_RUN);
        wait_in     = (state_reg == ST_WAIT_IN);
        sel_bits    = cnt_reg[N-3:0];
        ph_bits     = cnt_reg[N-1:N-2];
        frame_end   = run && (&cnt_reg);
        // A latched count of 1 means this frame's decrement takes it to zero.
        exit_run    = frame_end && (stop_pend_reg || stop ||
                      (!forever_reg && frames_left_reg == NFRM_W'(1)));
        // Stop wins over a simultaneous sample in WAIT_IN: no sample is taken.
        take_sample = wait_in && in_valid && !stop;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (start) state_next = ST_WAIT_IN;
            ST_WAIT_IN: begin
                if (stop)          state_next = ST_IDLE;
                else if (in_valid) state_next = ST_RUN;
            end
            ST_RUN:     if (frame_end) state_next = exit_run ? ST_IDLE : ST_WAIT_IN;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reg         <= '0;
            frames_left_reg <= '0;
            forever_reg     <= 1'b0;
            stop_pend_reg   <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            done_reg <= (wait_in && stop) || exit_run;
            // Free-running in RUN; wraps to zero at frame end, held at zero elsewhere.
            cnt_reg  <= run ? cnt_reg + N'(1) : '0;
            if (state_reg == ST_IDLE && start) begin
                frames_left_reg <= num_frames;
                forever_reg     <= (num_frames == '0);
                stop_pend_reg   <= 1'b0;
            end else begin
                if (frame_end && !forever_reg)
                    frames_left_reg <= frames_left_reg - NFRM_W'(1);
                if (exit_run)
                    stop_pend_reg <= 1'b0;
                else if (run && stop)
                    stop_pend_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        in_ready    = wait_in && !stop;
        sample_en   = take_sample;
        sc_sel      = sel_bits;
        phase       = ph_bits;
        phase_start = '0;
        phase_done  = '0;
        if (run) begin
            if (sel_bits == '0) phase_start[ph_bits] = 1'b1;
            if (&sel_bits)      phase_done[ph_bits]  = 1'b1;
        end
        mux_sel     = mux_lookup(ph_bits);
        frame_done  = frame_end;
        busy        = (state_reg != ST_IDLE);
        done        = done_reg;
    end

endmodule

// File: tb/tb_sc_frame_scheduler.sv
// Directed bench for sc_frame_scheduler at N=12: table-driven single-frame walk plus
// hand-written multi-frame, stop, and mid-run reset sequences.
module tb_sc_frame_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] num_frames = 16'd0;
    logic        in_ready, sample_en, frame_done, busy, done;
    logic [9:0]  sc_sel;
    logic [1:0]  phase, mux_sel;
    logic [3:0]  phase_start, phase_done;

    int pass_cnt = 0;
    int total_cnt = 0;

    sc_frame_scheduler #(.N(12), .NFRM_W(16)) dut (
        .clock(clock), .reset(reset), .start(start), .num_frames(num_frames),
        .stop(stop), .in_valid(in_valid), .in_ready(in_ready), .sample_en(sample_en),
        .sc_sel(sc_sel), .phase(phase), .phase_start(phase_start), .phase_done(phase_done),
        .mux_sel(mux_sel), .frame_done(frame_done), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         k;
        logic [3:0] ps;
        logic [3:0] pd;
        logic       fd;
        logic       bsy;
        logic       dn;
        logic [1:0] mux;
        logic [1:0] ph;
        logic [9:0] sel;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Inputs change 2 units after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ti, se_cnt, inv_bad;
        int gap, se, fd, dn, wcyc, gapbad, runbad, last_se, pitch_bad;
        int fd2_at, dn_at, se_after, stop_sent, hit, fd_at, d_at;
        logic prev_se;

        tbl[0]  = '{1,    4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 10'd0};
        tbl[1]  = '{500,  4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 10'd499};
        tbl[2]  = '{1024, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 10'd1023};
        tbl[3]  = '{1025, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 2'd1, 10'd0};
        tbl[4]  = '{2048, 4'b0000, 4'b0010, 1'b0, 1'b1, 1'b0, 2'd2, 2'd1, 10'd1023};
        tbl[5]  = '{2049, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 10'd0};
        tbl[6]  = '{3072, 4'b0000, 4'b0100, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 10'd1023};
        tbl[7]  = '{3073, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 2'd3, 10'd0};
        tbl[8]  = '{4096, 4'b0000, 4'b1000, 1'b1, 1'b1, 1'b0, 2'd1, 2'd3, 10'd1023};
        tbl[9]  = '{4097, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 10'd0};
        tbl[10] = '{4098, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 10'd0};

        // Reset state
        repeat (3) tick();
        settle();
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_mux_sel", int'(mux_sel), 3);
        chk("rst_strobes", int'({phase_start, phase_done, frame_done, sample_en, done}), 0);
        tick();
        reset = 1'b0;

        // Single frame, table-driven
        tick();
        start = 1'b1; num_frames = 16'd1; in_valid = 1'b1;
        settle();
        chk("idle_busy", int'(busy), 0);
        tick();
        start = 1'b0;
        settle();
        chk("t_sample_en", int'(sample_en), 1);
        chk("t_in_ready", int'(in_ready), 1);
        ti = 0; se_cnt = 0; inv_bad = 0;
        for (int k = 1; k <= 4100; k++) begin
            tick();
            start = (k == 500);
            settle();
            se_cnt += int'(sample_en);
            if (phase_done != 4'b0 && (sc_sel != 10'd1023 || !$onehot(phase_done))) inv_bad++;
            if (ti < 11 && tbl[ti].k == k) begin
                chk($sformatf("ps@%0d", k),   int'(phase_start), int'(tbl[ti].ps));
                chk($sformatf("pd@%0d", k),   int'(phase_done),  int'(tbl[ti].pd));
                chk($sformatf("fd@%0d", k),   int'(frame_done),  int'(tbl[ti].fd));
                chk($sformatf("busy@%0d", k), int'(busy),        int'(tbl[ti].bsy));
                chk($sformatf("done@%0d", k), int'(done),        int'(tbl[ti].dn));
                chk($sformatf("mux@%0d", k),  int'(mux_sel),     int'(tbl[ti].mux));
                chk($sformatf("ph@%0d", k),   int'(phase),       int'(tbl[ti].ph));
                chk($sformatf("sel@%0d", k),  int'(sc_sel),      int'(tbl[ti].sel));
                ti++;
            end
        end
        chk("tbl_entries_hit", ti, 11);
        chk("run1_extra_samples", se_cnt, 0);
        chk("phase_done_onehot_at_1023", inv_bad, 0);

        // Stop while waiting for input: no sample, done next cycle
        tick();
        start = 1'b1; num_frames = 16'd5; in_valid = 1'b0;
        tick();
        start = 1'b0; stop = 1'b1;
        settle();
        chk("wstop_sample_en", int'(sample_en), 0);
        tick();
        stop = 1'b0;
        settle();
        chk("wstop_busy", int'(busy), 0);
        chk("wstop_done", int'(done), 1);
        tick();
        settle();
        chk("wstop_done_pulse", int'(done), 0);

        // Three frames, input stalled 10 cycles after each frame end
        tick();
        start = 1'b1; num_frames = 16'd3; in_valid = 1'b1;
        tick();
        start = 1'b0;
        gap = 0; se = 0; fd = 0; dn = 0; wcyc = 0; gapbad = 0; runbad = 0;
        last_se = -1; pitch_bad = 0; prev_se = 1'b0;
        for (int c = 0; c < 12400; c++) begin
            if (gap > 0) begin in_valid = 1'b0; gap--; end
            else in_valid = 1'b1;
            settle();
            if (prev_se && !(busy && phase_start == 4'b0001 && sc_sel == 10'd0 && !in_ready)) runbad++;
            if (in_ready) begin
                wcyc++;
                if (phase != 2'd0 || sc_sel != 10'd0) gapbad++;
            end
            if (sample_en) begin
                se++;
                if (last_se >= 0 && c - last_se != 4107) pitch_bad++;
                last_se = c;
            end
            prev_se = sample_en;
            if (frame_done) begin fd++; gap = 10; end
            if (done) dn++;
            tick();
        end
        chk("m3_samples", se, 3);
        chk("m3_frames", fd, 3);
        chk("m3_done", dn, 1);
        chk("m3_wait_cycles", wcyc, 23);
        chk("m3_cnt_frozen_in_gap", gapbad, 0);
        chk("m3_run_after_sample", runbad, 0);
        chk("m3_frame_pitch", pitch_bad, 0);

        // Unbounded run, stop at cnt=100 of frame 2
        start = 1'b1; num_frames = 16'd0; in_valid = 1'b1;
        tick();
        start = 1'b0;
        se = 0; fd = 0; dn = 0; fd2_at = -1; dn_at = -1; se_after = 0; stop_sent = 0;
        for (int c = 0; c < 8300; c++) begin
            stop = 1'b0;
            settle();
            if (sample_en) begin
                se++;
                if (dn > 0) se_after++;
            end
            if (frame_done) begin fd++; if (fd == 2) fd2_at = c; end
            if (done) begin dn++; dn_at = c; end
            if (fd == 1 && stop_sent == 0 && busy && !in_ready && phase == 2'd0 && sc_sel == 10'd100) begin
                stop = 1'b1;
                stop_sent = 1;
            end
            tick();
        end
        stop = 1'b0;
        chk("stop_sent", stop_sent, 1);
        chk("stop_frames", fd, 2);
        chk("stop_frame2_end", fd2_at, 8193);
        chk("stop_done_at", dn_at, 8194);
        chk("stop_done_count", dn, 1);
        chk("stop_samples", se, 2);
        chk("stop_no_sample_after", se_after, 0);

        // Reset in the middle of a frame, then a clean run
        start = 1'b1; num_frames = 16'd0; in_valid = 1'b1;
        tick();
        start = 1'b0;
        hit = 0;
        for (int c = 0; c < 2100; c++) begin
            settle();
            if (busy && phase == 2'd1 && sc_sel == 10'd976) begin
                reset = 1'b1;
                hit = 1;
                break;
            end
            tick();
        end
        chk("mrst_reached_2000", hit, 1);
        tick();
        settle();
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_phase", int'(phase), 0);
        chk("mrst_sc_sel", int'(sc_sel), 0);
        chk("mrst_strobes", int'({phase_start, phase_done, frame_done, done, in_ready, sample_en}), 0);
        tick();
        reset = 1'b0;
        tick();
        start = 1'b1; num_frames = 16'd1;
        tick();
        start = 1'b0;
        settle();
        chk("mrst_restart_sample", int'(sample_en), 1);
        fd_at = -1; d_at = -1;
        for (int k = 1; k <= 4100; k++) begin
            tick();
            settle();
            if (k == 1) begin
                chk("mrst_restart_ps", int'(phase_start), 1);
                chk("mrst_restart_sel", int'(sc_sel), 0);
            end
            if (frame_done && fd_at < 0) fd_at = k;
            if (done && d_at < 0) d_at = k;
        end
        chk("mrst_restart_fd", fd_at, 4096);
        chk("mrst_restart_done", d_at, 4097);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
